// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_TICK    = 7;
  localparam int unsigned SAMPLE_TICK = OVERSAMPLE - 1;
  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned TICK_W      = 4;
  localparam int unsigned BIT_W       = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO, reusable for RX and TX paths.
// Ports: clk, rst_n (async active-low), push/din write side, pop read side,
//        dout = head entry, empty, full, count (entries held).
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_do;
  logic             push_do;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign pop_do  = pop && !empty;
  assign push_do = push && (!full || pop_do);

  // Storage and pointers; memory cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_do) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_do) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with receive FIFO, driven by a shared 16x baud strobe.
// Ports: clk_i, rst_n_i (async active-low), brg_stb_i 16x strobe, rx_i serial,
//        rd_i pop, err_clr_i clear sticky flags; dout_o/empty_o/full_o/count_o
//        FIFO status, frame_err_o and overrun_o sticky errors.
// Optional macro UART_RX_PARITY_EN adds a parity bit (parity_odd_i selects odd)
// and the sticky parity_err_o flag.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     brg_stb_i,
  input  logic                     rx_i,
  input  logic                     rd_i,
  input  logic                     err_clr_i,
`ifdef UART_RX_PARITY_EN
  input  logic                     parity_odd_i,
  output logic                     parity_err_o,
`endif
  output logic [DATA_BITS-1:0]     dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     frame_err_o,
  output logic                     overrun_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  rx_state_e              state_q, state_nxt;
  logic [TICK_W-1:0]      tick_q, tick_nxt;
  logic [BIT_W-1:0]       bit_q, bit_nxt;
  logic [DATA_BITS-1:0]   shift_q, shift_nxt;
  logic                   stop_c;
  logic                   frame_set_c;
  logic                   good_c;
  logic                   overrun_set_c;

  // Input synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  logic par_q, par_nxt;
  logic par_bad_c;
  logic parity_set_c;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      tick_q  <= tick_nxt;
      bit_q   <= bit_nxt;
      shift_q <= shift_nxt;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_nxt;
`endif
    end
  end

  // Next-state logic; everything advances only on strobe cycles.
  always_comb begin
    state_nxt = state_q;
    tick_nxt  = tick_q;
    bit_nxt   = bit_q;
    shift_nxt = shift_q;
    stop_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_q;
`endif
    if (brg_stb_i) begin
      case (state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            state_nxt = RX_START;
            tick_nxt  = '0;
          end
        end
        RX_START: begin
          if (tick_q == TICK_W'(MID_TICK)) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            tick_nxt = tick_q + TICK_W'(1);
          end
        end
        RX_DATA: begin
          tick_nxt = tick_q + TICK_W'(1);
          if (tick_q == TICK_W'(SAMPLE_TICK)) begin
            shift_nxt = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_nxt   = bit_q + BIT_W'(1);
            if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = RX_PARITY;
`else
              state_nxt = RX_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          tick_nxt = tick_q + TICK_W'(1);
          if (tick_q == TICK_W'(SAMPLE_TICK)) begin
            par_nxt   = rx_s;
            state_nxt = RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          tick_nxt = tick_q + TICK_W'(1);
          if (tick_q == TICK_W'(SAMPLE_TICK)) begin
            stop_c    = 1'b1;
            state_nxt = RX_IDLE;
          end
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  // Frame outcome at the stop-bit sample; framing error outranks parity.
  assign frame_set_c = stop_c && !rx_s;
`ifdef UART_RX_PARITY_EN
  assign par_bad_c     = par_q != (^shift_q ^ parity_odd_i);
  assign parity_set_c  = stop_c && rx_s && par_bad_c;
  assign good_c        = stop_c && rx_s && !par_bad_c;
`else
  assign good_c        = stop_c && rx_s;
`endif
  // A same-cycle read frees a slot in a full FIFO, so no overrun then.
  assign overrun_set_c = good_c && full_o && !rd_i;

  // Sticky error flags; a new event wins over a clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o  <= frame_set_c   || (frame_err_o  && !err_clr_i);
      overrun_o    <= overrun_set_c || (overrun_o    && !err_clr_i);
`ifdef UART_RX_PARITY_EN
      parity_err_o <= parity_set_c  || (parity_err_o && !err_clr_i);
`endif
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .push  (good_c),
    .din   (shift_q),
    .pop   (rd_i),
    .dout  (dout_o),
    .empty (empty_o),
    .full  (full_o),
    .count (count_o)
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial UART receiver with built-in receive FIFO; the receive-side counterpart of the existing UART_TX.
- Samples rx_i using the shared 16x baud-rate strobe from the UARTController BRG, assembles 8N1 frames LSB-first and pushes good bytes into a first-word-fall-through FIFO.
- Read side plugs into UARTController's register decode, in place of its single-byte RX holding register.
- Reports FIFO status and sticky framing and overrun errors.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, 2..16.
- SYNC_STAGES, 2, number of rx_i synchronizer flops; minimum 2.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- brg_stb_i  in  1  one-cycle strobe at 16x baud rate
- rx_i  in  1  serial input; idles high
- rd_i  in  1  pop head byte; ignored when empty
- err_clr_i  in  1  clear sticky error flags
- dout_o  out  8  FIFO head byte; valid when empty_o=0
- empty_o  out  1  FIFO empty
- full_o  out  1  FIFO full
- count_o  out  $clog2(DEPTH)+1  bytes held
- frame_err_o  out  1  sticky: stop bit sampled low
- overrun_o  out  1  sticky: good byte dropped because FIFO full

Behaviour:
- Reset, asynchronous on rst_n_i low, with immediate effect mid-frame:
  - synchronizer flops set to 1
  - state IDLE, all counters 0
  - FIFO empty: empty_o=1, full_o=0, count_o=0, dout_o=0x00
  - frame_err_o=0, overrun_o=0
- Synchronizer: rx_s is rx_i delayed by SYNC_STAGES clk_i cycles. All FSM logic uses rx_s and advances only on cycles with brg_stb_i=1.
- Counters: tick (4-bit, wraps 15->0) and bit_cnt (3-bit).
- IDLE: on stb with rx_s=0, go to START with tick=0.
- START: on stb, tick++. At tick==7 (mid start bit):
  - rx_s=0: go to DATA, tick=0, bit_cnt=0.
  - rx_s=1: false start; return to IDLE, nothing logged.
- DATA: on stb, tick++. At tick==15, shift rx_s into shift[7] (shift right, LSB first), then bit_cnt++. After the 8th bit, go to STOP.
- STOP: on stb, tick++. At tick==15 (mid stop bit), sample rx_s:
  - rx_s=1 and FIFO not full: push shift.
  - rx_s=1 and FIFO full: drop the byte, set overrun_o.
  - rx_s=0: discard the byte, set frame_err_o.
  - In all cases return to IDLE in the same cycle, so a start bit that follows directly is caught.
- Frame latency: the push register write happens on the stb cycle at STOP tick 15. empty_o deasserts and dout_o updates on the next clk_i edge.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; wrap handled by the extra MSB.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - dout_o = mem[rd_ptr] (FWFT).
- Simultaneous push and rd:
  - Not full: both occur, count unchanged.
  - Full: the pop frees a slot, so the push is accepted and no overrun is flagged.
  - Empty: the push occurs and the rd is ignored.
- Errors: err_clr_i clears both flags. If err_clr_i coincides with a new error event, the set wins.
- brg_stb_i held continuously high is legal (BRG divisor 1); the FSM then advances every clock.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and samples at tick==15.
  - Added input parity_odd_i: 1 selects odd parity, 0 selects even.
  - Added sticky output parity_err_o, reset 0, cleared by err_clr_i.
  - A parity mismatch discards the byte and sets parity_err_o. A framing error takes precedence in flag setting.
- When undefined: 8N1 only; the parity port and logic are absent.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  - OVERSAMPLE=16, MID_TICK=7, SAMPLE_TICK=15
  - DATA_BITS=8
- One sub-module, sync_fifo, parameterised by DEPTH and WIDTH. It provides push/pop/full/empty/count and is reusable for a future TX FIFO.

Test Plan:
- Reset then idle, brg_stb_i tied high, rx_i=1 for 500 cycles -> empty_o=1, frame_err_o=0, count_o=0.
- UART_TX sends 0x75 (stb every cycle) -> empty_o falls exactly one cycle after the stop-bit stb at tick 15. dout_o=0x75. After rd_i pulse -> empty_o=1.
- rx_i low glitch of 3 stb ticks -> false start, count_o stays 0, no flags set.
- Frame 0xA5 with the stop bit forced to 0 -> frame_err_o=1, count_o=0. err_clr_i pulse -> frame_err_o=0.
- Send 0x01..0x05 back-to-back with DEPTH=4 and no reads:
  - full_o=1 after the 4th byte
  - 5th byte dropped, overrun_o=1
  - reads return 0x01,0x02,0x03,0x04
- FIFO full, rd_i asserted on the push cycle of byte 0x5A -> no overrun, count_o stays 4, last read returns 0x5A. Also assert rst_n_i low mid-DATA -> all outputs return to reset values immediately.
